// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: two-stage valid/ready 32-bit execute unit.
//   S1 holds the accepted operation and operands. S2 holds the computed
//   result and its flags for write-back.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   upstream handshake; alu_op, op_a, op_b are the payload
//   out_valid/out_ready downstream handshake; result, zero, err are the payload
//   ovf                 signed overflow on ADD/SUB (only with ALU_OVF_EN)
// Codes: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 110 SUB, 111 SLT,
//        101 undefined (result 0, err 1).
// Optional macro: ALU_OVF_EN adds the ovf port and its logic.
module alu_exec_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             err;
`ifdef ALU_OVF_EN
    logic             ovf;
`endif
  } rsp_t;

  logic s1_v;
  req_t s1;
  rsp_t s2, nxt;
  logic s2_adv;

  // S2 takes S1 whenever it is empty or its current result leaves this cycle.
  assign s2_adv   = s1_v && (!out_valid || out_ready);
  assign in_ready = !s1_v || s2_adv;

  // Result/flag computation from S1.
  logic [WIDTH-1:0] sum, dif;
  assign sum = s1.a + s1.b;
  assign dif = s1.a - s1.b;

  always_comb begin
    nxt = '0;
    case (s1.op)
      OP_AND:  nxt.res = s1.a & s1.b;
      OP_OR:   nxt.res = s1.a | s1.b;
      OP_ADD:  nxt.res = sum;
      OP_XOR:  nxt.res = s1.a ^ s1.b;
      OP_NOR:  nxt.res = ~(s1.a | s1.b);
      OP_SUB:  nxt.res = dif;
      OP_SLT:  nxt.res = {{(WIDTH-1){1'b0}}, ($signed(s1.a) < $signed(s1.b))};
      default: nxt.err = 1'b1;  // 101: result stays 0
    endcase
`ifdef ALU_OVF_EN
    // ADD: like-signed operands, result sign flips.
    // SUB: unlike-signed operands, result sign differs from A.
    if (s1.op == OP_ADD)
      nxt.ovf = (s1.a[WIDTH-1] == s1.b[WIDTH-1]) && (sum[WIDTH-1] != s1.a[WIDTH-1]);
    else if (s1.op == OP_SUB)
      nxt.ovf = (s1.a[WIDTH-1] != s1.b[WIDTH-1]) && (dif[WIDTH-1] != s1.a[WIDTH-1]);
`endif
    nxt.zero = (nxt.res == '0);
  end

  // S1: operand register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1   <= '0;
    end else if (in_valid && in_ready) begin
      s1_v <= 1'b1;
      s1   <= '{op: alu_op, a: op_a, b: op_b};
    end else if (s2_adv) begin
      s1_v <= 1'b0;
    end
  end

  // S2: output register; contents only change on s2_adv, so they hold
  // steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      s2        <= '0;
      s2.zero   <= 1'b1;
    end else if (s2_adv) begin
      out_valid <= 1'b1;
      s2        <= nxt;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign result = s2.res;
  assign zero   = s2.zero;
  assign err    = s2.err;
`ifdef ALU_OVF_EN
  assign ovf    = s2.ovf;
`endif

endmodule

// File: doc/alu_exec_pipe.md
Name: alu_exec_pipe

Overview:
- Two-stage, valid/ready-handshaked 32-bit execute unit: the consumer side of the 3-bit ALU control code driven by the ALU control decoder.
- Accepts an operation code plus two operands, computes the result, and presents it with zero/error flags to the write-back side.
- Sits between the register-read/decode stage and write-back in the datapath; provides backpressure so downstream stalls propagate upstream without data loss.

Parameters:
- WIDTH, 32, operand/result width in bits (≥ 2).

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  stage can accept this cycle
- alu_op  in  3  ALU control code
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- out_valid  out  1  result held on out_* is valid
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  computed value
- zero  out  1  result == 0
- err  out  1  alu_op was undefined (3'b101)
- ovf  out  1  signed overflow (present only with ALU_OVF_EN)

Behaviour:
- Code map: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 110 SUB (A−B), 111 SLT (signed A<B → 1, else 0, zero-extended), 101 undefined → result 0, err=1.
- ADD/SUB wrap modulo 2^WIDTH; no carry output.
- S1 (operand register): s1_v, s1_op, s1_a, s1_b. S2 (output register): out_valid, result, zero, err[, ovf].
- s2_adv = s1_v && (!out_valid || out_ready). On s2_adv, S2 loads computed values from S1, out_valid←1.
- If out_valid && out_ready && !s2_adv, out_valid←0.
- in_ready = !s1_v || s2_adv; combinational, and may depend on out_ready.
- On in_valid && in_ready, S1 captures alu_op/op_a/op_b and s1_v←1. Otherwise, if s2_adv, s1_v←0.
- Latency: operation accepted on edge k is presented on out_* after edge k+1. Throughput is 1 op/cycle when out_ready stays high.
- Backpressure: with out_ready low, at most 2 ops are held (S1 + S2) and in_ready=0. No op is dropped or duplicated; order is strictly preserved.
- out_* held stable while out_valid && !out_ready.
- zero, err, and ovf are registered with result and always describe the presented result.
- Simultaneous out handshake and new input: both complete in the same cycle, with no bubble.
- Reset (any time, including mid-operation): s1_v=0, out_valid=0, result=0, zero=1, err=0, ovf=0. Data in flight is discarded. in_ready=1 while rst is low and S1 is empty.
- No X propagation: S1 data registers also reset to 0.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined: port ovf exists. ovf=1 when ADD operands share a sign and the result sign differs, or when SUB operands differ in sign and the result sign differs from A. ovf=0 for all other codes. ovf is registered with result.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- ADD, alu_op=010, A=5, B=7, out_ready=1 → after 2 edges: result=12, zero=0, err=0; out_valid high exactly 1 cycle.
- SUB, alu_op=110, A=7, B=7 → result=0, zero=1. SLT, alu_op=111, A=0xFFFFFFFF, B=1 → result=1. SLT with A=1, B=0xFFFFFFFF → result=0.
- Undefined code: alu_op=101, A=3, B=4 → result=0, err=1, zero=1. A following AND 0xF0&0x3C → 0x30 with err=0.
- Backpressure: issue 4 back-to-back ops (OR 1|2, XOR 6^3, NOR 0,0, ADD 1+1) with out_ready=0 for 4 cycles. Required: in_ready=0 once 2 ops are held, first output stays 3 stable. Then raise out_ready → outputs 3, 5, 0xFFFFFFFF, 2 in order, no gaps.
- Reset mid-flight: 2 ops held, pulse rst asynchronously between edges → out_valid=0 and in_ready=1 immediately. After release, the next ADD 2+2 yields 4 with no stale outputs.
- With ALU_OVF_EN: ADD 0x7FFFFFFF+1 → result 0x80000000, ovf=1. SUB 0x80000000−1 → ovf=1. ADD 1+1 → ovf=0.
